// File: rtl/fp_input_exception_unit.sv
// Purpose : classifies an FP operand pair (NaN/Inf/invalid) ahead of the adder, keeps sticky result flags and an invalid-op counter.
// Latency : 2 cycles from accept to out_valid (S1 class registers, S2 combined exception vector); one pair per cycle.
// Backpressure: valid/ready skid-free two-stage pipe; in_ready depends only on registered state and out_ready.
//
// Ports: clk/resetn (async active-low); in_valid/in_ready/in_a/in_b/in_op operand channel;
//        out_valid/out_ready/out_a/out_b/out_op/out_exc classified channel ({INV,A_NaN,B_NaN,A_Inf,B_Inf});
//        flags_valid/flags_in/flags_clr -> sticky_flags; inv_count counts delivered invalid pairs (saturating).
module fp_input_exception_unit #(
    parameter int DWIDTH   = 16,
    parameter int EXPONENT = 5,
    parameter int MANTISSA = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b,
    output logic              out_op,
    output logic [4:0]        out_exc,
    input  logic              flags_valid,
    input  logic [4:0]        flags_in,
    input  logic              flags_clr,
    output logic [4:0]        sticky_flags,
    output logic [7:0]        inv_count
);

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Field classification of one operand.
    function automatic logic is_nan(input logic [DWIDTH-1:0] x);
        return (&x[DWIDTH-2 -: EXPONENT]) & (|x[MANTISSA-1:0]);
    endfunction

    function automatic logic is_inf(input logic [DWIDTH-1:0] x);
        return (&x[DWIDTH-2 -: EXPONENT]) & ~(|x[MANTISSA-1:0]);
    endfunction

    // Stage 1 state
    logic              v1;
    logic [DWIDTH-1:0] a1;
    logic [DWIDTH-1:0] b1;
    logic              op1;
    logic              a_nan1;
    logic              b_nan1;
    logic              a_inf1;
    logic              b_inf1;
    logic              effsub1;

    // Stage 2 state (drives the outputs directly)
    logic              v2;

    logic s2_load;
    logic s1_load;
    logic exc_inv;
    logic xfer_inv;

    assign s2_load   = ~v2 | out_ready;
    assign in_ready  = ~v1 | s2_load;
    assign s1_load   = in_ready;
    assign out_valid = v2;

    // Inf - Inf with effective subtraction is the only invalid case not caused by a NaN.
    assign exc_inv  = a_nan1 | b_nan1 | (a_inf1 & b_inf1 & effsub1);
    assign xfer_inv = v2 & out_ready & out_exc[4];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1      <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            op1     <= 1'b0;
            a_nan1  <= 1'b0;
            b_nan1  <= 1'b0;
            a_inf1  <= 1'b0;
            b_inf1  <= 1'b0;
            effsub1 <= 1'b0;
        end else if (s1_load) begin
            v1 <= in_valid;
            // Data only captured for a real pair; bubbles leave it untouched.
            if (in_valid) begin
                a1      <= in_a;
                b1      <= in_b;
                op1     <= in_op;
                a_nan1  <= is_nan(in_a);
                b_nan1  <= is_nan(in_b);
                a_inf1  <= is_inf(in_a);
                b_inf1  <= is_inf(in_b);
                effsub1 <= in_a[DWIDTH-1] ^ in_b[DWIDTH-1] ^ in_op;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v2      <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
            out_op  <= 1'b0;
            out_exc <= '0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                out_a   <= a1;
                out_b   <= b1;
                out_op  <= op1;
                out_exc <= {exc_inv, a_nan1, b_nan1, a_inf1, b_inf1};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sticky_flags <= '0;
        end else if (flags_clr) begin
            sticky_flags <= flags_valid ? flags_in : 5'b0;
        end else if (flags_valid) begin
            sticky_flags <= sticky_flags | flags_in;
        end
    end

    // A clear coinciding with an invalid delivery counts that delivery.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inv_count <= '0;
        end else if (flags_clr) begin
            inv_count <= xfer_inv ? 8'd1 : 8'd0;
        end else if (xfer_inv && (inv_count != CNT_MAX)) begin
            inv_count <= inv_count + 8'd1;
        end
    end

endmodule
